char_scan_ctrl: RTL and testbench
=================================

Name: char_scan_ctrl

Overview:
- Sequences the 16x16 character-code ROM and the downstream font ROM for the text overlay of the VGA pipeline.
- Tracks the beam position against a fixed text window and drives the character-cell address char_xy = {row, col}.
- Drives the glyph-line index to the font ROM and the pixel index within the glyph.
- Delays the VGA timing and RGB by two cycles so they stay aligned with the two registered ROM stages.

Parameters:
- XPOS, 64: window left edge, in pixels.
- YPOS, 64: window top edge, in lines.
- COLS, 16: character columns (the code ROM is fixed at 16).
- ROWS, 16: character rows (fixed at 16).
- GLYPH_W, 8: glyph width in pixels (power of two).
- GLYPH_H, 16: glyph height in lines (power of two).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount_in  in  11  beam x
- vcount_in  in  11  beam y
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
- rgb_in  in  12  background pixel
- char_xy  out  8  [7:4] row, [3:0] col; goes to the code ROM
- char_line  out  4  glyph line; goes to the font ROM
- pix_idx  out  3  pixel within glyph, aligned to the font byte (2-cycle delay)
- in_window  out  1  aligned flag: the pixel lies inside the text window
- hcount_out, vcount_out  out  11  delayed by 2
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed by 2
- rgb_out  out  12  delayed by 2 (border override when the option is on)

Behaviour:
- Reset: all outputs 0, all counters 0, FSM in IDLE. Reset during any state returns to IDLE on the next edge. Nothing resumes mid-frame; scanning restarts at the next frame's YPOS line.
- Window: W = COLS*GLYPH_W (128), H = ROWS*GLYPH_H (256). x in window when XPOS <= hcount_in < XPOS+W. y in window when YPOS <= vcount_in < YPOS+H.
- Counters: px_cnt [2:0], col_cnt [3:0], line_cnt [3:0], row_cnt [3:0]. No division or multiplication; comparisons use constants only.
- FSM states:
  - IDLE: wait for vcount_in == YPOS at hcount_in == 0, then clear line_cnt and row_cnt and go to WAIT_X.
  - WAIT_X: at hcount_in == XPOS, clear px_cnt and col_cnt and go to SCAN.
  - SCAN: each clock px_cnt++. When px_cnt wraps (== GLYPH_W-1), col_cnt++. When hcount_in == XPOS+W-1, go to LINE_END.
  - LINE_END: line_cnt++. On line_cnt wrap (== GLYPH_H-1), row_cnt++. If line_cnt and row_cnt were both at max, go to FRAME_DONE; otherwise go to WAIT_X.
  - FRAME_DONE: wait for vcount_in == 0, then go to IDLE.
- char_xy and char_line are driven combinationally from the counters while in SCAN (stage 0) and hold their last value outside SCAN.
- The code ROM registers char_code (stage 1); the font ROM registers its byte (stage 2).
- pix_idx and in_window pass through two register stages. in_window is 1 only for pixels captured in SCAN.
- Timing, hcount/vcount and rgb are delayed by exactly two registers, so outputs at cycle n+2 correspond to inputs at cycle n.
- Boundaries:
  - XPOS+W > 800 or YPOS+H > 600 is illegal; an elaboration-time assertion catches it.
  - Window and blanking overlapping: in_window is forced to 0 whenever hblnk_in or vblnk_in is set.
  - A beam jump (vcount_in == 0 seen in any state other than IDLE) forces IDLE.

Optional Feature:
- Macro: CHAR_SCAN_BORDER_EN.
- Defined: rgb_out = 12'hFFF on the 1-pixel ring just outside the window:
  - x = XPOS-1 or x = XPOS+W, with y in [YPOS-1, YPOS+H];
  - y = YPOS-1 or y = YPOS+H, with x in the same range.
  - The test is on pre-delay coordinates, and the result is delayed with the rgb path.
- Undefined: rgb_out is the plain 2-cycle-delayed rgb_in.

Decomposition:
- vga_pkg gains:
  - TXT_XPOS, TXT_YPOS, TXT_COLS, TXT_ROWS, GLYPH_W, GLYPH_H constants;
  - BORDER_RGB = 12'hFFF;
  - typedef scan_state_t enum {IDLE, WAIT_X, SCAN, LINE_END, FRAME_DONE}.
- One sub-module, delay_line #(WIDTH, CLK_DEL=2), carries the timing, count, rgb, pix_idx and in_window bundle.

Test Plan:
- rst held 3 cycles mid-SCAN -> all outputs 0 the cycle after assertion; the next in_window=1 appears only at frame N+1 (vcount 64, hcount 64), two cycles late.
- Beam at (hcount 64, vcount 64) -> char_xy=8'h00, char_line=0. Beam at (72, 64) -> char_xy=8'h01.
- Beam at (191, 64) -> char_xy=8'h0F. Beam at (64, 80) -> char_xy=8'h10, char_line=0. Beam at (64, 79) -> char_line=15.
- Beam at (191, 319) (last window pixel) -> char_xy=8'hFF, FSM reaches FRAME_DONE. Pixels at (64, 320) -> in_window=0.
- Random timing/rgb stream -> every output equals its input from exactly 2 cycles earlier. pix_idx at output = (hcount_out-64)[2:0] inside the window.
- With CHAR_SCAN_BORDER_EN defined -> rgb_out=FFF at (63, 100), (192, 100), (100, 63) and (100, 320). rgb_out=rgb_in(delayed) at (64, 100).

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: text-window constants and scan FSM state type shared by the
// character-scan controller.
package vga_pkg;
  localparam int TXT_XPOS = 64;
  localparam int TXT_YPOS = 64;
  localparam int TXT_COLS = 16;
  localparam int TXT_ROWS = 16;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam logic [11:0] BORDER_RGB = 12'hFFF;
  typedef enum logic [2:0] {IDLE, WAIT_X, SCAN, LINE_END, FRAME_DONE} scan_state_t;
endpackage

// File: rtl/delay_line.sv
// delay_line: CLK_DEL-deep register pipeline with synchronous clear.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int CLK_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  logic [WIDTH-1:0] pipe_q [CLK_DEL];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= data_i;
      for (int i = 1; i < CLK_DEL; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign data_o = pipe_q[CLK_DEL-1];
endmodule

// File: rtl/char_scan_ctrl.sv
// char_scan_ctrl: text-window scanner driving code/font ROM addresses and a
// 2-cycle aligned timing/rgb bundle; CHAR_SCAN_BORDER_EN adds a white border ring.
module char_scan_ctrl import vga_pkg::*; #(
  parameter int XPOS = TXT_XPOS,
  parameter int YPOS = TXT_YPOS,
  parameter int COLS = TXT_COLS,
  parameter int ROWS = TXT_ROWS,
  parameter int GW   = GLYPH_W,
  parameter int GH   = GLYPH_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  output logic [2:0]  pix_idx,
  output logic        in_window,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  localparam int W = COLS * GW;
  localparam int H = ROWS * GH;
  if (XPOS < 1 || XPOS + W > 800 || YPOS + H > 600) begin : g_bad_window
    $error("char_scan_ctrl: text window outside 800x600");
  end
  scan_state_t state_q;
  logic [2:0] px_q;
  logic [3:0] col_q, line_q, row_q;
  logic [7:0] char_xy_q;
  logic [3:0] char_line_q;
  logic scan, x_in, y_in, win_d;
  logic [11:0] rgb_sel;
  logic [41:0] stage0, stage2;
  assign scan = state_q == SCAN;
  assign x_in = hcount_in >= 11'(XPOS) && hcount_in < 11'(XPOS + W);
  assign y_in = vcount_in >= 11'(YPOS) && vcount_in < 11'(YPOS + H);
  assign win_d = scan && x_in && y_in && !hblnk_in && !vblnk_in;
  assign char_xy = scan ? {row_q, col_q} : char_xy_q;
  assign char_line = scan ? line_q : char_line_q;
  // SCAN is entered one pixel early so the counters already address the pixel at XPOS
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {px_q, col_q, line_q, row_q} <= '0;
      char_xy_q <= '0;
      char_line_q <= '0;
    end else begin
      char_xy_q <= char_xy;
      char_line_q <= char_line;
      if (state_q != IDLE && vcount_in == '0) state_q <= IDLE;
      else case (state_q)
        IDLE: if (vcount_in == 11'(YPOS) && hcount_in == '0) begin
          line_q <= '0;
          row_q <= '0;
          state_q <= WAIT_X;
        end
        WAIT_X: if (hcount_in == 11'(XPOS - 1)) begin
          px_q <= '0;
          col_q <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          px_q <= px_q + 3'd1;
          if (px_q == 3'(GW - 1)) col_q <= col_q + 4'd1;
          if (hcount_in == 11'(XPOS + W - 1)) state_q <= LINE_END;
        end
        LINE_END: begin
          line_q <= line_q + 4'd1;
          if (line_q == 4'(GH - 1)) row_q <= row_q + 4'd1;
          state_q <= (line_q == 4'(GH - 1) && row_q == 4'(ROWS - 1)) ? FRAME_DONE : WAIT_X;
        end
        FRAME_DONE: if (vcount_in == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef CHAR_SCAN_BORDER_EN
  logic x_ring, y_ring, on_edge;
  assign x_ring = hcount_in >= 11'(XPOS - 1) && hcount_in <= 11'(XPOS + W);
  assign y_ring = vcount_in >= 11'(YPOS - 1) && vcount_in <= 11'(YPOS + H);
  assign on_edge = hcount_in == 11'(XPOS - 1) || hcount_in == 11'(XPOS + W) ||
                   vcount_in == 11'(YPOS - 1) || vcount_in == 11'(YPOS + H);
  assign rgb_sel = (x_ring && y_ring && on_edge) ? BORDER_RGB : rgb_in;
`else
  assign rgb_sel = rgb_in;
`endif
  assign stage0 = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_sel, px_q, win_d};
  delay_line #(.WIDTH(42), .CLK_DEL(2)) u_delay (
    .clk(clk),
    .rst(rst),
    .data_i(stage0),
    .data_o(stage2)
  );
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, pix_idx, in_window} = stage2;
endmodule

// File: tb/tb_char_scan_ctrl.sv
// tb_char_scan_ctrl: compressed-frame stimulus checked against an arithmetic
// window model, a table of address checkpoints and reset/frame-end sequences.
module tb_char_scan_ctrl;
  import vga_pkg::*;
  logic clk = 0, rst = 1;
  logic [10:0] hcount_in = 0, vcount_in = 0;
  logic hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
  logic [11:0] rgb_in = 0;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic [2:0] pix_idx;
  logic in_window, hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [10:0] hcount_out, vcount_out;
  logic [11:0] rgb_out;

  char_scan_ctrl dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_xy(char_xy), .char_line(char_line), .pix_idx(pix_idx),
    .in_window(in_window), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h, v;
    logic hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [2:0] pix;
    logic win;
  } bun_t;
  typedef struct {
    int h;
    int v;
    logic [7:0] xy;
    logic [3:0] line;
  } vec_t;

  vec_t vecs[8];
  bun_t hist1 = '0, hist2 = '0;
  bit rst_prev = 1, active = 0, table_en = 0, blank_en = 1, await_first = 0;
  logic [7:0] last_xy = 0;
  logic [3:0] last_line = 0;
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at h=%0d v=%0d t=%0t: got %0h expected %0h", name, hcount_in, vcount_in, $time, act, exp);
    end
  endtask

  function automatic bit on_border(input int h, input int v);
    return h >= 63 && h <= 192 && v >= 63 && v <= 320 && (h == 63 || h == 192 || v == 63 || v == 320);
  endfunction

  task automatic tick(input int h, input int v, input bit r);
    bit scan_now;
    logic [7:0] exy;
    logic [3:0] eln;
    bun_t cur, e;
    @(posedge clk);
    #1;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rst = r;
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
    hblnk_in = blank_en && $urandom_range(0, 15) == 0;
    vblnk_in = blank_en && $urandom_range(0, 31) == 0;
    rgb_in = 12'($urandom);
    @(negedge clk);
    scan_now = active && h >= 64 && h < 192 && v >= 64 && v < 320;
    exy = scan_now ? {4'((v - 64) / 16), 4'((h - 64) / 8)} : last_xy;
    eln = scan_now ? 4'((v - 64) % 16) : last_line;
    chk("char_xy", 64'(char_xy), 64'(exy));
    chk("char_line", 64'(char_line), 64'(eln));
    e = rst_prev ? '0 : hist2;
    chk("counts_out", 64'({hcount_out, vcount_out}), 64'({e.h, e.v}));
    chk("timing_out", 64'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'({e.hs, e.vs, e.hb, e.vb}));
    chk("rgb_out", 64'(rgb_out), 64'(e.rgb));
    chk("in_window", 64'(in_window), 64'(e.win));
    if (e.win) chk("pix_idx", 64'(pix_idx), 64'(e.pix));
    if (table_en)
      for (int i = 0; i < 8; i++)
        if (vecs[i].h == h && vecs[i].v == v) begin
          chk("table_xy", 64'(char_xy), 64'(vecs[i].xy));
          chk("table_line", 64'(char_line), 64'(vecs[i].line));
        end
    if (await_first && in_window) begin
      chk("first_win_h", 64'(hcount_out), 64'd64);
      chk("first_win_v", 64'(vcount_out), 64'd64);
      await_first = 0;
    end
    cur = '0;
    if (!r) begin
      cur.h = 11'(h);
      cur.v = 11'(v);
      {cur.hs, cur.vs, cur.hb, cur.vb} = {hsync_in, vsync_in, hblnk_in, vblnk_in};
`ifdef CHAR_SCAN_BORDER_EN
      cur.rgb = on_border(h, v) ? 12'hFFF : rgb_in;
`else
      cur.rgb = rgb_in;
`endif
      cur.pix = 3'((h - 64) % 8);
      cur.win = scan_now && !hblnk_in && !vblnk_in;
    end
    hist2 = hist1;
    hist1 = cur;
    rst_prev = r;
    if (r) begin
      active = 0;
      last_xy = '0;
      last_line = '0;
    end else begin
      last_xy = exy;
      last_line = eln;
      if (v == 0) active = 0;
      else if (!active && h == 0 && v == 64) active = 1;
    end
  endtask

  task automatic scan_line(input int v, input bit with_rst);
    tick(0, v, 0);
    for (int h = 60; h <= 195; h++) tick(h, v, with_rst && h >= 100 && h < 103);
  endtask

  initial begin
    vecs[0] = '{64, 64, 8'h00, 4'd0};
    vecs[1] = '{72, 64, 8'h01, 4'd0};
    vecs[2] = '{191, 64, 8'h0F, 4'd0};
    vecs[3] = '{64, 80, 8'h10, 4'd0};
    vecs[4] = '{64, 79, 8'h00, 4'd15};
    vecs[5] = '{191, 319, 8'hFF, 4'd15};
    vecs[6] = '{100, 200, 8'h84, 4'd8};
    vecs[7] = '{135, 130, 8'h48, 4'd2};
    for (int i = 0; i < 4; i++) tick(0, 0, 1);
    table_en = 1;
    scan_line(0, 0);
    for (int v = 63; v <= 320; v++) scan_line(v, 0);
    table_en = 0;
    chk("frame_done", 64'(dut.state_q), 64'(FRAME_DONE));
    blank_en = 0;
    scan_line(0, 0);
    for (int v = 64; v <= 69; v++) scan_line(v, 0);
    scan_line(70, 1);
    for (int v = 71; v <= 75; v++) scan_line(v, 0);
    await_first = 1;
    scan_line(0, 0);
    for (int v = 62; v <= 66; v++) scan_line(v, 0);
    chk("first_win_seen", 64'(await_first), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
